// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: data width, canonical NOP and the fetch entry payload.
package pipeline_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch queue storage: DEPTH entries, one write port, one combinational read port.
module fetch_queue_mem
    import pipeline_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  fetch_entry_t  wr_data,
    input  logic [AW-1:0] rd_addr,
    output fetch_entry_t  rd_data
);

    fetch_entry_t mem_q [DEPTH];
    fetch_entry_t mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, buffers {pc, instr} pairs for decode.
// Optional FETCH_QUEUE_BYPASS_EN passes the current fetch straight to decode when empty.
module fetch_queue
    import pipeline_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [ILEN-1:0]            imem_rdata,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [ILEN-1:0]            out_instr,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic         full_c, empty_c, bypass_c, push_c, pop_c;
    fetch_entry_t wr_data_c;
    fetch_entry_t rd_data_c;

    assign full_c  = (count_q == CW'(DEPTH));
    assign empty_c = (count_q == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    // Reset gating keeps decode outputs at zero while reset is held.
    assign bypass_c = empty_c && !redirect_valid && out_ready && reset;
`else
    assign bypass_c = 1'b0;
`endif

    assign push_c = !full_c && !redirect_valid && !bypass_c;
    assign pop_c  = !empty_c && out_ready && !redirect_valid;

    always_comb begin
        wr_data_c       = '0;
        wr_data_c.pc    = fetch_pc_q;
        wr_data_c.instr = imem_rdata;
    end

    // Next-state: redirect flushes everything; otherwise advance on push or bypass.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push_c || bypass_c) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push_c && !pop_c) begin
                count_d = count_q + CW'(1);
            end else if (pop_c && !push_c) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_c),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data_c),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data_c)
    );

    assign imem_addr = fetch_pc_q;
    assign occupancy = count_q;
    assign out_valid = !redirect_valid && (!empty_c || bypass_c);
    assign out_pc    = bypass_c ? fetch_pc_q : rd_data_c.pc;
    assign out_instr = bypass_c ? imem_rdata : rd_data_c.instr;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-level reference model checked every cycle plus directed literal pins.
module tb_fetch_queue;
    import pipeline_pkg::*;

    localparam int unsigned DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc, out_instr;
    logic [2:0]  occupancy;

    logic [31:0] w_imem_addr, w_imem_rdata, w_out_pc, w_out_instr;
    logic        w_redirect_valid = 1'b0;
    logic [31:0] w_redirect_pc = '0;
    logic        w_out_ready = 1'b1;
    logic        w_out_valid;
    logic [2:0]  w_occupancy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign imem_rdata   = imem_addr + 32'h100;
    assign w_imem_rdata = w_imem_addr + 32'h100;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .occupancy(occupancy)
    );

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .reset(reset), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_pc(w_out_pc),
        .out_instr(w_out_instr), .occupancy(w_occupancy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: a plain queue of fetched words and a fetch counter.
    fetch_entry_t mq[$];
    logic [31:0]  mfetch = 32'h0;

    always @(negedge clk) begin
        bit          byp, exp_valid;
        logic [31:0] exp_pc, exp_instr;
        if (!reset) begin
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_pc", out_pc, 32'd0);
            chk("rst_instr", out_instr, 32'd0);
            chk("rst_occ", 32'(occupancy), 32'd0);
            chk("rst_imem", imem_addr, 32'd0);
            mq.delete();
            mfetch = 32'h0;
        end else begin
            byp       = BYP && mq.size() == 0 && !redirect_valid && out_ready;
            exp_valid = !redirect_valid && (mq.size() != 0 || byp);
            chk("valid", 32'(out_valid), 32'(exp_valid));
            chk("imem_addr", imem_addr, mfetch);
            chk("occupancy", 32'(occupancy), 32'(mq.size()));
            if (exp_valid) begin
                exp_pc    = byp ? mfetch : mq[0].pc;
                exp_instr = byp ? mfetch + 32'h100 : mq[0].instr;
                chk("out_pc", out_pc, exp_pc);
                chk("out_instr", out_instr, exp_instr);
            end
            // Advance the model with the inputs the DUT will see on the next rising edge.
            if (redirect_valid) begin
                mq.delete();
                mfetch = redirect_pc & ~32'h3;
            end else if (byp) begin
                mfetch = mfetch + 32'd4;
            end else begin
                bit do_push;
                do_push = mq.size() < DEPTH;
                if (mq.size() != 0 && out_ready) void'(mq.pop_front());
                if (do_push) begin
                    mq.push_back('{pc: mfetch, instr: mfetch + 32'h100});
                    mfetch = mfetch + 32'd4;
                end
            end
        end
    end

    task automatic drv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [39:0] pat;
        logic [31:0] e;

        // Reset values
        repeat (2) drv();
        smp();
        chk("pin_rst_imem", imem_addr, 32'h0);
        chk("pin_rst_valid", 32'(out_valid), 32'd0);
        chk("pin_rst_occ", 32'(occupancy), 32'd0);
        chk("pin_w_rst_imem", w_imem_addr, 32'hFFFF_FFF8);

        // Streaming from reset release with decode always ready
        drv(); reset = 1'b1;
        smp();
        chk("pin_a0_imem", imem_addr, 32'h0);
        chk("pin_a0_valid", 32'(out_valid), BYP ? 32'd1 : 32'd0);
        chk("pin_a0_occ", 32'(occupancy), 32'd0);
        if (BYP) chk("pin_a0_byp_instr", out_instr, 32'h100);
        chk("pin_w_a0", w_imem_addr, 32'hFFFF_FFF8);
        drv(); smp();
        chk("pin_a1_imem", imem_addr, 32'h4);
        chk("pin_a1_pc", out_pc, BYP ? 32'h4 : 32'h0);
        chk("pin_a1_instr", out_instr, BYP ? 32'h104 : 32'h100);
        chk("pin_w_a1", w_imem_addr, 32'hFFFF_FFFC);
        drv(); smp();
        chk("pin_a2_imem", imem_addr, 32'h8);
        chk("pin_a2_pc", out_pc, BYP ? 32'h8 : 32'h4);
        chk("pin_w_a2", w_imem_addr, 32'h0000_0000);
        chk("pin_w_a2_pc", w_out_pc, BYP ? 32'h0 : 32'hFFFF_FFFC);

        // Decode stalled for 10 cycles after reset: queue fills, fetch holds
        drv(); reset = 1'b0; out_ready = 1'b0;
        drv(); reset = 1'b1;
        repeat (10) drv();
        smp();
        chk("pin_full_occ", 32'(occupancy), 32'd4);
        chk("pin_full_imem", imem_addr, 32'h10);
        drv(); out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            smp();
            e = 32'(k) * 32'd4;
            chk("pin_drain_pc", out_pc, e);
            if (k < 4) drv();
        end

        // Redirect to 0x203 with 3 entries held
        drv(); redirect_valid = 1'b1; redirect_pc = 32'h203;
        smp();
        chk("pin_rd_occ", 32'(occupancy), 32'd3);
        chk("pin_rd_valid", 32'(out_valid), 32'd0);
        drv(); redirect_valid = 1'b0;
        smp();
        chk("pin_rd1_occ", 32'(occupancy), 32'd0);
        chk("pin_rd1_imem", imem_addr, 32'h200);
        chk("pin_rd1_valid", 32'(out_valid), BYP ? 32'd1 : 32'd0);
        drv(); smp();
        chk("pin_rd2_valid", 32'(out_valid), 32'd1);
        chk("pin_rd2_pc", out_pc, BYP ? 32'h204 : 32'h200);

        // Asynchronous reset with 2 entries held
        drv(); redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b0;
        drv(); redirect_valid = 1'b0;
        drv(); drv();
        smp();
        chk("pin_two_occ", 32'(occupancy), 32'd2);
        drv(); reset = 1'b0;
        #1;
        chk("pin_async_occ", 32'(occupancy), 32'd0);
        chk("pin_async_valid", 32'(out_valid), 32'd0);
        chk("pin_async_imem", imem_addr, 32'h0);
        drv(); reset = 1'b1;

        // Mixed stall/redirect traffic, including a PC wrap, checked by the model
        pat = 40'hB3_5C_F0_96_E7;
        for (int i = 0; i < 40; i++) begin
            drv();
            out_ready      = pat[i];
            redirect_valid = (i == 15) || (i == 30);
            redirect_pc    = (i == 15) ? 32'hFFFF_FFF2 : 32'h0000_1235;
        end
        drv(); redirect_valid = 1'b0; out_ready = 1'b1;
        repeat (3) drv();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
